// File: rtl/calc_op_controller.sv
// calc_op_controller: debounces the four active-low front-panel buttons, runs the
// power/operation state machine (Off, Soma, Sub, Mult, On) and sequences the
// arithmetic on the latched operands for the downstream display selector.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   B1..B4     active-low buttons (Soma, Sub, Mult, power toggles)
//   N1, N2     unsigned W-bit operands
//   ESTADO     Off=0, Soma=1, Sub=2, Mult=3, On=4
//   RESULT     2W-bit unsigned magnitude of the result
//   NEG        subtraction result is negative
//   BUSY       shift-add multiplication in progress
//   RES_VALID  RESULT/NEG match the latched operands and current ESTADO
module calc_op_controller #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned W         = 7
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            B1,
  input  logic            B2,
  input  logic            B3,
  input  logic            B4,
  input  logic [W-1:0]    N1,
  input  logic [W-1:0]    N2,
  output logic [2:0]      ESTADO,
  output logic [2*W-1:0]  RESULT,
  output logic            NEG,
  output logic            BUSY,
  output logic            RES_VALID
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned SW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_SOMA = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_MULT = 3'd3;
  localparam logic [2:0] S_ON   = 3'd4;

  // Button index: 0=B1, 1=B2, 2=B3, 3=B4
  logic [3:0]    btn_raw;
  logic [3:0]    sync1, sync2, stable, press;
  logic [CW-1:0] cnt [4];

  logic [2:0]    state, state_nxt;
  logic [W-1:0]  a, a_nxt, b, b_nxt;
  logic [RW-1:0] acc, acc_nxt, result, result_nxt;
  logic [SW-1:0] step, step_nxt;
  logic          neg, neg_nxt, busy, busy_nxt, res_valid, res_valid_nxt;
  logic          start_op;
  logic [RW-1:0] term, acc_sum;

  assign btn_raw   = {B4, B3, B2, B1};
  assign ESTADO    = state;
  assign RESULT    = result;
  assign NEG       = neg;
  assign BUSY      = busy;
  assign RES_VALID = res_valid;

  function automatic logic is_op(input logic [2:0] s);
    return (s == S_SOMA) || (s == S_SUB) || (s == S_MULT);
  endfunction

  // Synchronizers and debouncers; press is a one-cycle pulse on a stable 1->0
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_OFF;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      step      <= '0;
      result    <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      acc       <= acc_nxt;
      step      <= step_nxt;
      result    <= result_nxt;
      neg       <= neg_nxt;
      busy      <= busy_nxt;
      res_valid <= res_valid_nxt;
    end
  end

  // Next-state, operand tracking and arithmetic sequencing
  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    b_nxt         = b;
    acc_nxt       = acc;
    step_nxt      = step;
    result_nxt    = result;
    neg_nxt       = neg;
    busy_nxt      = busy;
    res_valid_nxt = res_valid;
    start_op      = 1'b0;
    term          = '0;
    acc_sum       = '0;

    // Button events, B4 > B3 > B2 > B1; losers are dropped
    if (state == S_OFF) begin
      if (press[3]) state_nxt = S_ON;
    end else if (press[3]) begin
      state_nxt = S_OFF;
    end else if (press[2]) begin
      state_nxt = (state == S_MULT) ? S_ON : S_MULT;
    end else if (press[1]) begin
      state_nxt = (state == S_SUB) ? S_ON : S_SUB;
    end else if (press[0]) begin
      state_nxt = (state == S_SOMA) ? S_ON : S_SOMA;
    end

    if (state_nxt != state) begin
      // Any transition (including a multiply abort) drops the current result
      result_nxt    = '0;
      neg_nxt       = 1'b0;
      busy_nxt      = 1'b0;
      res_valid_nxt = 1'b0;
      start_op      = is_op(state_nxt);
    end else if (is_op(state)) begin
      if (busy) begin
        // One multiplier bit per cycle, LSB first; operand changes ignored
        term    = b[step] ? (RW'(a) << step) : '0;
        acc_sum = acc + term;
        acc_nxt = acc_sum;
        if (step == SW'(W - 1)) begin
          busy_nxt      = 1'b0;
          result_nxt    = acc_sum;
          res_valid_nxt = 1'b1;
        end else begin
          step_nxt = step + SW'(1);
        end
      end else if ((N1 != a) || (N2 != b)) begin
        start_op = 1'b1;
      end else if (!res_valid) begin
        if (state == S_SOMA) begin
          result_nxt    = RW'(a) + RW'(b);
          neg_nxt       = 1'b0;
          res_valid_nxt = 1'b1;
        end else if (state == S_SUB) begin
          if (a >= b) begin
            result_nxt = RW'(a - b);
            neg_nxt    = 1'b0;
          end else begin
            result_nxt = RW'(b - a);
            neg_nxt    = 1'b1;
          end
          res_valid_nxt = 1'b1;
        end else begin
          start_op = 1'b1;
        end
      end
    end

    // Latch operands and (re)start the operation of the next state
    if (start_op) begin
      a_nxt         = N1;
      b_nxt         = N2;
      acc_nxt       = '0;
      step_nxt      = '0;
      result_nxt    = '0;
      neg_nxt       = 1'b0;
      res_valid_nxt = 1'b0;
      busy_nxt      = (state_nxt == S_MULT);
    end
  end

endmodule

// File: tb/tb_calc_op_controller.sv
// Scoreboard bench for calc_op_controller: directed button/operand sequences push
// expected results; a monitor pops one on every RES_VALID rising edge.
module tb_calc_op_controller;

  typedef struct packed {
    logic [2:0]  st;
    logic [13:0] res;
    logic        neg;
  } exp_t;

  logic        clk, rst;
  logic        b1, b2, b3, b4;
  logic [6:0]  n1, n2;
  logic [2:0]  estado;
  logic [13:0] result;
  logic        neg, busy, res_valid;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  logic mon_en = 1'b0;
  logic prev_rv = 1'b0;

  calc_op_controller #(.DB_CYCLES(4), .W(7)) dut (
    .CLK(clk), .RST(rst), .B1(b1), .B2(b2), .B3(b3), .B4(b4),
    .N1(n1), .N2(n2), .ESTADO(estado), .RESULT(result), .NEG(neg),
    .BUSY(busy), .RES_VALID(res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_res(input int st, input int res, input int ng);
    exp_t e;
    e.st  = 3'(st);
    e.res = 14'(res);
    e.neg = 1'(ng);
    q.push_back(e);
  endtask

  // Hold buttons (mask bit 3=B4..0=B1) low until the event edge has passed
  task automatic press_hold(input logic [3:0] m);
    {b4, b3, b2, b1} = ~m;
    repeat (7) @(negedge clk);
  endtask

  task automatic release_all();
    {b4, b3, b2, b1} = 4'b1111;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: idle outputs in Off/On, scoreboard pop on each new valid result
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (estado == 3'd0 || estado == 3'd4)
        chk("idle_outputs", int'({result, neg, busy, res_valid}), 0);
      if (res_valid && !prev_rv) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got state %0d result %0d, expected no result", estado, result);
        end else begin
          e = q.pop_front();
          chk("res_state", int'(estado), int'(e.st));
          chk("res_value", int'(result), int'(e.res));
          chk("res_neg", int'(neg), int'(e.neg));
        end
      end
    end
    prev_rv = res_valid;
  end

  initial begin
    rst = 1'b1;
    {b4, b3, b2, b1} = 4'b1111;
    n1 = '0;
    n2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_state", int'(estado), 0);
    chk("reset_busy_valid", int'({busy, res_valid, neg}), 0);

    // Power-on latency: B4 low just before edge 1, ESTADO changes at edge 7
    b4 = 1'b0;
    repeat (6) @(negedge clk);
    chk("b4_edge6_still_off", int'(estado), 0);
    @(negedge clk);
    chk("b4_edge7_on", int'(estado), 4);
    release_all();
    press_hold(4'b1000);
    chk("b4_again_off", int'(estado), 0);
    release_all();
    press_hold(4'b1000);
    chk("b4_on", int'(estado), 4);
    release_all();

    // Soma 25+17, then operand change to 30 restarts
    n1 = 7'd25;
    n2 = 7'd17;
    expect_res(1, 42, 0);
    press_hold(4'b0001);
    chk("soma_entered", int'(estado), 1);
    chk("soma_valid_latency", int'(res_valid), 0);
    release_all();
    expect_res(1, 55, 0);
    n2 = 7'd30;
    @(negedge clk);
    chk("soma_relatch_invalid", int'(res_valid), 0);
    repeat (3) @(negedge clk);

    // Sub 12-40: operand change in Soma recomputes first
    n1 = 7'd12;
    n2 = 7'd40;
    expect_res(1, 52, 0);
    repeat (3) @(negedge clk);
    expect_res(2, 28, 1);
    press_hold(4'b0010);
    chk("sub_entered", int'(estado), 2);
    release_all();
    press_hold(4'b0010);
    chk("sub_toggle_on", int'(estado), 4);
    chk("sub_exit_cleared", int'({result, res_valid}), 0);
    release_all();

    // Mult 127*127: BUSY for 7 cycles
    n1 = 7'd127;
    n2 = 7'd127;
    expect_res(3, 16129, 0);
    press_hold(4'b0100);
    chk("mult_entered", int'(estado), 3);
    chk("mult_busy_e", int'(busy), 1);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      chk("mult_busy_run", int'(busy), 1);
    end
    @(negedge clk);
    chk("mult_done_busy", int'(busy), 0);
    chk("mult_done_value", int'(result), 16129);
    release_all();

    // Operand change during BUSY is deferred until completion
    expect_res(3, 381, 0);
    expect_res(3, 12700, 0);
    n1 = 7'd3;
    @(negedge clk);
    chk("mult_restart_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    n1 = 7'd100;
    repeat (5) @(negedge clk);
    chk("mult_ignored_change", int'({res_valid, result}), int'({1'b1, 14'd381}));
    @(negedge clk);
    chk("mult_second_restart", int'({res_valid, busy}), 1);
    repeat (10) @(negedge clk);

    // Abort: B1+B2 during BUSY, B2 wins; Sub of 100-50
    expect_res(2, 50, 0);
    b1 = 1'b0;
    b2 = 1'b0;
    repeat (3) @(negedge clk);
    n2 = 7'd50;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", int'(busy), 1);
    @(negedge clk);
    chk("abort_state_sub", int'(estado), 2);
    chk("abort_busy_clear", int'(busy), 0);
    release_all();

    // RST mid-multiply
    press_hold(4'b0100);
    chk("rst_mult_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    {b4, b3, b2, b1} = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", int'(estado), 0);
    chk("rst_mid_outputs", int'({result, neg, busy, res_valid}), 0);
    repeat (8) @(negedge clk);

    // Glitch on B3 and simultaneous B4+B3
    press_hold(4'b1000);
    chk("on_after_rst", int'(estado), 4);
    release_all();
    expect_res(1, 150, 0);
    press_hold(4'b0001);
    release_all();
    b3 = 1'b0;
    repeat (2) @(negedge clk);
    b3 = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_ignored", int'(estado), 1);
    press_hold(4'b1100);
    chk("b4_beats_b3", int'(estado), 0);
    release_all();

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
